winograd_4x4_data_transformation: RTL and testbench
===================================================

Name: winograd_4x4_data_transformation

Overview:
- Input-tile transform of Winograd F(2x2,3x3) convolution: computes Y = B^T · d · B on a 4x4 tile of signed fixed-point samples.
- B^T = [[1,0,-1,0],[0,1,1,0],[0,-1,1,0],[0,1,0,-1]].
- Sits between the tile fetcher and the elementwise multiplier, whose other operand is the pre-transformed kernel.
- Two-stage registered pipeline with a valid flag. Adders/subtractors only, no multipliers.

Parameters:
- DATA_WIDTH, 32, bit width of every input and output element (two's complement).
- FRAC_WIDTH, 16, fractional bits (Q16.16 by default). Informational only: the transform needs no rescaling, so the binary point passes through unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data holds a valid tile this cycle.
- data  input  16 x DATA_WIDTH signed (unpacked array [16])  input tile, row-major, index = 4*row+col.
- out_valid  output  1  result holds a valid transformed tile.
- result  output  16 x DATA_WIDTH signed (unpacked array [16])  transformed tile, row-major.

Behaviour:
- Reset (asynchronous, while rst=1): all pipeline registers clear to 0; out_valid=0; every result element = 0.
- Stage 1 (row transform, T = B^T·d), registered on the clk edge where in_valid=1. For each column c:
  - T0c = d0c − d2c
  - T1c = d1c + d2c
  - T2c = d2c − d1c
  - T3c = d1c − d3c
  - Each T element is held at DATA_WIDTH+1 bits, sign-extended; no loss.
- Stage 2 (column transform, Y = T·B), registered on the next edge. For each row r:
  - Yr0 = Tr0 − Tr2
  - Yr1 = Tr1 + Tr2
  - Yr2 = Tr2 − Tr1
  - Yr3 = Tr1 − Tr3
  - Computed at DATA_WIDTH+2 bits.
- Output saturation: each Y element saturates to DATA_WIDTH signed.
  - Values > 2^(DATA_WIDTH−1)−1 clamp to the maximum.
  - Values < −2^(DATA_WIDTH−1) clamp to the minimum.
  - No wrap-around.
- Latency: 2 cycles. Tile accepted at edge k appears on result with out_valid=1 after edge k+1.
- Throughput: one tile per cycle; back-to-back tiles are supported.
- Valid propagation:
  - out_valid is a 2-deep delay of in_valid.
  - When in_valid=0, the stage registers hold their previous values; result keeps the last tile and out_valid drops.
- No backpressure: the consumer must accept whenever out_valid=1.
- Reset mid-operation: tiles in flight are discarded. After rst falls, the first out_valid follows the first post-reset in_valid by 2 cycles.
- result is driven only from registers; no combinational path from data to result.

Decomposition:
- Shared package winograd_pkg holds:
  - tile size constants (TILE=4, TILE_ELEMS=16);
  - the default DATA_WIDTH/FRAC_WIDTH;
  - a saturate function (wide signed value -> DATA_WIDTH).
- One natural sub-module: winograd_1d_transform, the 4-point combinational butterfly (v0−v2, v1+v2, v2−v1, v1−v3), parameterised on input width with output width = input width+1.
  - Instantiate 4 times for columns (stage 1) and 4 times for rows (stage 2).

Test Plan:
- Reset: assert rst with in_valid=1 and a nonzero tile -> out_valid=0 and all result=0 immediately and throughout reset.
- Directed tile, Q16.16, all other elements 0, with a=0x0000_0101 and b=0x0000_0202:
  - Input: d0=a, d5=b, d6=b, d8=b, d11=b, d14=b, d15=a.
  - Required result (idx 0..15), with out_valid=1 exactly 2 cycles after input:
  - FFFFFEFF,0,0,00000202, 0,00000404,0,0, 00000404,FFFFFBFC,0,FFFFFBFC, 0,00000202,FFFFFDFE,00000303.
- Impulse: only d5=0x0001_0000 (1.0) -> result5,13 = 0x0001_0000; result6,14 = 0xFFFF_0000; result7,15 = 0x0001_0000; result9 = 0xFFFF_0000; result10 = 0x0001_0000; result11 = 0xFFFF_0000; all others 0.
- Saturation:
  - All d = 0x7FFF_FFFF -> result5 = 0x7FFF_FFFF (true value 4·max), all others 0.
  - All d = 0x8000_0000 -> result5 = 0x8000_0000.
- Streaming: three different tiles on consecutive cycles, then in_valid=0 -> three consecutive correct outputs with out_valid=1, then out_valid=0 and result holds the third tile.
- Mid-stream reset: pulse rst while one tile is in stage 1 -> that tile never appears; out_valid stays 0 until 2 cycles after the next in_valid.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) input-tile transform.
//   TILE / TILE_ELEMS          : tile geometry (4x4, 16 elements, row-major)
//   DEFAULT_DATA_WIDTH / _FRAC : default element format (Q16.16)
//   SAT_WIDTH                  : width of the generic saturate() argument
//   saturate()                 : clamp a wide signed value to a narrower signed range
package winograd_pkg;

  localparam int TILE               = 4;
  localparam int TILE_ELEMS         = TILE * TILE;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FRAC_WIDTH = 16;

  // saturate() works on a fixed wide carrier so one function serves any
  // DATA_WIDTH; callers sign-extend in and truncate the clamped value out.
  localparam int SAT_WIDTH = 64;

  function automatic logic signed [SAT_WIDTH-1:0] saturate(
    input logic signed [SAT_WIDTH-1:0] value,
    input int unsigned                 width
  );
    logic signed [SAT_WIDTH-1:0] max_val;
    logic signed [SAT_WIDTH-1:0] min_val;
    max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val = -max_val - 64'sd1;
    if (value > max_val) return max_val;
    if (value < min_val) return min_val;
    return value;
  endfunction

endpackage

// File: rtl/winograd_1d_transform.sv
// 4-point Winograd B^T butterfly, purely combinational.
//   v : four signed inputs of IN_WIDTH bits
//   y : four signed outputs of IN_WIDTH+1 bits (wide enough that no sum overflows)
//       y0 = v0 - v2, y1 = v1 + v2, y2 = v2 - v1, y3 = v1 - v3
module winograd_1d_transform
  import winograd_pkg::*;
#(
  parameter int IN_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic signed [IN_WIDTH-1:0] v [TILE],
  output logic signed [IN_WIDTH:0]   y [TILE]
);

  logic signed [IN_WIDTH:0] ext [TILE];

  for (genvar i = 0; i < TILE; i++) begin : g_ext
    // Sized cast of a signed operand sign-extends, so the sums below are exact.
    assign ext[i] = (IN_WIDTH + 1)'(v[i]);
  end

  assign y[0] = ext[0] - ext[2];
  assign y[1] = ext[1] + ext[2];
  assign y[2] = ext[2] - ext[1];
  assign y[3] = ext[1] - ext[3];

endmodule

// File: rtl/winograd_4x4_data_transformation.sv
// Winograd F(2x2,3x3) input-tile transform: result = sat(B^T * data * B).
// Two registered stages: stage 1 applies B^T down each column (T = B^T*d),
// stage 2 applies B across each row (Y = T*B) and saturates to DATA_WIDTH.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset, clears the whole pipeline
//   in_valid  : data carries a tile this cycle
//   data      : input tile, row-major (index = 4*row + col)
//   out_valid : result carries a freshly transformed tile (in_valid delayed by 2)
//   result    : transformed tile, row-major; holds the last tile when idle
module winograd_4x4_data_transformation
  import winograd_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAC_WIDTH = DEFAULT_FRAC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data   [TILE_ELEMS],
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] result [TILE_ELEMS]
);

  localparam int T_WIDTH = DATA_WIDTH + 1;
  localparam int Y_WIDTH = DATA_WIDTH + 2;

  // The binary point passes straight through (coefficients are +-1), so
  // FRAC_WIDTH only needs to describe a legal format.
  if (Y_WIDTH > SAT_WIDTH) begin : g_width_check
    $error("DATA_WIDTH too large for saturate() carrier");
  end
  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= DATA_WIDTH) begin : g_frac_check
    $error("FRAC_WIDTH must lie in [0, DATA_WIDTH)");
  end

  // Stage 1 wiring, indexed [col][row].
  logic signed [DATA_WIDTH-1:0] col_in  [TILE][TILE];
  logic signed [T_WIDTH-1:0]    col_out [TILE][TILE];
  logic signed [T_WIDTH-1:0]    t_next  [TILE_ELEMS];
  logic signed [T_WIDTH-1:0]    t_reg   [TILE_ELEMS];
  logic                         stage1_valid;

  // Stage 2 wiring, indexed [row][col].
  logic signed [T_WIDTH-1:0]    row_in  [TILE][TILE];
  logic signed [Y_WIDTH-1:0]    row_out [TILE][TILE];
  logic signed [DATA_WIDTH-1:0] y_sat   [TILE_ELEMS];

  for (genvar c = 0; c < TILE; c++) begin : g_cols
    for (genvar r = 0; r < TILE; r++) begin : g_elems
      assign col_in[c][r]        = data[TILE*r + c];
      assign t_next[TILE*r + c]  = col_out[c][r];
    end
    winograd_1d_transform #(.IN_WIDTH(DATA_WIDTH)) u_col (
      .v (col_in[c]),
      .y (col_out[c])
    );
  end

  for (genvar r = 0; r < TILE; r++) begin : g_rows
    for (genvar c = 0; c < TILE; c++) begin : g_elems
      assign row_in[r][c] = t_reg[TILE*r + c];
      // Full-precision stage-2 sum is clamped here, never wrapped.
      assign y_sat[TILE*r + c] =
        DATA_WIDTH'(saturate(SAT_WIDTH'(row_out[r][c]), DATA_WIDTH));
    end
    winograd_1d_transform #(.IN_WIDTH(T_WIDTH)) u_row (
      .v (row_in[r]),
      .y (row_out[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are pipeline registers, not a RAM, so every element is
      // reset; the outputs must read zero while rst is high.
      stage1_valid <= 1'b0;
      out_valid    <= 1'b0;
      for (int i = 0; i < TILE_ELEMS; i++) begin
        t_reg[i]  <= '0;
        result[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let both stages read the values from
      // before this edge, which is what makes this a two-deep pipeline.
      stage1_valid <= in_valid;
      out_valid    <= stage1_valid;
      if (in_valid)     t_reg  <= t_next;
      if (stage1_valid) result <= y_sat;
    end
  end

endmodule

// File: tb/tb_winograd_4x4_data_transformation.sv
// Self-checking bench for winograd_4x4_data_transformation.
// A matrix-arithmetic reference model predicts every output cycle; directed
// tiles with hand-computed literal results pin both the model and the DUT.
module tb_winograd_4x4_data_transformation;

  typedef logic signed [31:0] tile_t [16];

  localparam int BT [4][4] = '{'{1, 0, -1, 0},
                               '{0, 1,  1, 0},
                               '{0, -1, 1, 0},
                               '{0, 1,  0, -1}};

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  tile_t data;
  logic  out_valid;
  tile_t result;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b1;

  always #5 clk = ~clk;

  winograd_4x4_data_transformation dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data      (data),
    .out_valid (out_valid),
    .result    (result)
  );

  // ---------------- reference model ----------------
  function automatic void model(input tile_t d, output tile_t y);
    longint t [4][4];
    longint acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += BT[i][k] * longint'(d[4*k + j]);
        t[i][j] = acc;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += t[i][k] * BT[j][k];
        if (acc > 64'sd2147483647)       acc = 64'sd2147483647;
        else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        y[4*i + j] = 32'(acc);
      end
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One comparison per tile: reports the first differing element.
  task automatic check_tile(input string name, input tile_t actual,
                            input tile_t expected);
    int idx = 0;
    for (int i = 15; i >= 0; i--)
      if (actual[i] !== expected[i]) idx = i;
    check($sformatf("%s[%0d]", name, idx), actual[idx], expected[idx]);
  endtask

  // Accepted tiles, keyed by the edge number that captured them.
  int    edge_n = 0;
  int    acc_edge [$];
  tile_t exp_mem [0:1023];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_edge.delete();
    end else begin
      edge_n++;
      if (in_valid) begin
        tile_t y;
        model(data, y);
        exp_mem[edge_n % 1024] = y;
        acc_edge.push_back(edge_n);
      end
    end
  end

  // A tile captured at edge e is visible from edge e+1 on; out_valid only
  // for the cycle right after edge e+1.
  always @(negedge clk) begin
    if (cmp_en) begin
      tile_t exp_y;
      logic  exp_v;
      int    last;
      last  = -1;
      foreach (acc_edge[i]) if (acc_edge[i] + 1 <= edge_n) last = acc_edge[i];
      exp_v = (last >= 0) && (last == edge_n - 1);
      if (last >= 0) exp_y = exp_mem[last % 1024];
      else           foreach (exp_y[i]) exp_y[i] = '0;
      check("cycle out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      check_tile("cycle result", result, exp_y);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void zero_tile(output tile_t t);
    foreach (t[i]) t[i] = '0;
  endfunction

  // Drive one tile, then check the literal expectation two edges later.
  task automatic run_literal(input string name, input tile_t tile,
                             input tile_t expected);
    tile_t m;
    model(tile, m);
    check_tile({name, " model"}, m, expected);
    data = tile;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, " latency"}, {31'd0, out_valid}, 32'd0);
    step();
    check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check_tile(name, result, expected);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tile_t t, e, zeros, s1, s2, s3, m1, m2, m3, ab_tile, ab_exp;
    zero_tile(zeros);

    // Reset with a live tile on the input.
    foreach (t[i]) t[i] = 32'sh0001_0000 + i;
    data = t;
    in_valid = 1'b1;
    #1;
    check("reset out_valid immediate", {31'd0, out_valid}, 32'd0);
    check_tile("reset result immediate", result, zeros);
    repeat (3) step();
    check("reset out_valid held", {31'd0, out_valid}, 32'd0);
    check_tile("reset result held", result, zeros);
    in_valid = 1'b0;
    rst = 1'b0;
    step();

    // Directed Q16.16 tile.
    zero_tile(ab_tile);
    ab_tile[0] = 32'sh0000_0101; ab_tile[15] = 32'sh0000_0101;
    ab_tile[5] = 32'sh0000_0202; ab_tile[6]  = 32'sh0000_0202;
    ab_tile[8] = 32'sh0000_0202; ab_tile[11] = 32'sh0000_0202;
    ab_tile[14] = 32'sh0000_0202;
    ab_exp = '{32'hFFFF_FEFF, 0, 0, 32'h0000_0202,
               0, 32'h0000_0404, 0, 0,
               32'h0000_0404, 32'hFFFF_FBFC, 0, 32'hFFFF_FBFC,
               0, 32'h0000_0202, 32'hFFFF_FDFE, 32'h0000_0303};
    run_literal("directed", ab_tile, ab_exp);

    // Impulse of 1.0 at d5.
    zero_tile(t);
    t[5] = 32'sh0001_0000;
    zero_tile(e);
    e[5] = 32'h0001_0000;  e[13] = 32'h0001_0000;
    e[6] = 32'hFFFF_0000;  e[14] = 32'hFFFF_0000;
    e[7] = 32'h0001_0000;  e[15] = 32'h0001_0000;
    e[9] = 32'hFFFF_0000;  e[10] = 32'h0001_0000; e[11] = 32'hFFFF_0000;
    run_literal("impulse", t, e);

    // Positive and negative saturation.
    foreach (t[i]) t[i] = 32'sh7FFF_FFFF;
    zero_tile(e);
    e[5] = 32'h7FFF_FFFF;
    run_literal("sat max", t, e);
    foreach (t[i]) t[i] = 32'sh8000_0000;
    e[5] = 32'h8000_0000;
    run_literal("sat min", t, e);

    // Back-to-back streaming of three tiles.
    foreach (s1[i]) s1[i] = 32'(i * 32'sh1000) - 32'sh8000;
    foreach (s2[i]) s2[i] = (i % 3 == 0) ? 32'sh7FFF_0000 : -32'sh1234_5678;
    foreach (s3[i]) s3[i] = ((i / 4 + i % 4) % 2 == 0) ? 32'sh8000_0000 : 32'sh0000_00FF;
    model(s1, m1);
    model(s2, m2);
    model(s3, m3);
    data = s1; in_valid = 1'b1; step();
    data = s2; step();
    check("stream 1 valid", {31'd0, out_valid}, 32'd1);
    check_tile("stream 1", result, m1);
    data = s3; step();
    check("stream 2 valid", {31'd0, out_valid}, 32'd1);
    check_tile("stream 2", result, m2);
    in_valid = 1'b0; step();
    check("stream 3 valid", {31'd0, out_valid}, 32'd1);
    check_tile("stream 3", result, m3);
    step();
    check("stream idle valid", {31'd0, out_valid}, 32'd0);
    check_tile("stream hold", result, m3);

    // Reset while a tile sits in stage 1.
    data = s1; in_valid = 1'b1; step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check_tile("midreset result", result, zeros);
    step();
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      check("post-reset idle valid", {31'd0, out_valid}, 32'd0);
      check_tile("post-reset idle result", result, zeros);
    end
    run_literal("post-reset directed", ab_tile, ab_exp);
    repeat (2) step();

    @(posedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
